full_handshake_tx: RTL and testbench

//  TX-side of the four-phase CDC handshake: req=1 -> ack=1 -> req=0 -> ack=0.

---
 rtl/hs_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/full_handshake_tx.sv | 116 +++++++++++
 tb/tb_full_handshake_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared one-hot handshake state encoding for the TX and RX sides of the
// four-phase CDC handshake.
package hs_pkg;

  localparam logic [2:0] HS_IDLE     = 3'b001;
  localparam logic [2:0] HS_ASSERT   = 3'b010;
  localparam logic [2:0] HS_DEASSERT = 3'b100;

  typedef enum logic [2:0] {
    StIdle     = HS_IDLE,
    StAssert   = HS_ASSERT,
    StDeassert = HS_DEASSERT
  } hs_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/full_handshake_tx.sv
// TX side of a four-phase req/ack CDC handshake with a one-word pending buffer
// so local logic can queue the next word while a transfer is in flight.
module full_handshake_tx
  import hs_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid_i,
  input  logic [DW-1:0] tx_data_i,
  output logic          tx_ready_o,
  input  logic          ack_i,
  output logic          req_o,
  output logic [DW-1:0] req_data_o,
  output logic          idle_o,
  output logic          done_o
);

  hs_state_e     state_q, state_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          req_q, req_d;
  logic [DW-1:0] req_data_q, req_data_d;
  logic          done_q, done_d;
  logic          ack_s;
  logic          accept;
  logic          launch;

  sync_2ff #(
    .W (1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_i),
    .q_o (ack_s)
  );

  // Ready while the slot is empty, or when the slot drains into a launch this edge.
  assign tx_ready_o = !pend_vld_q || ((state_q == StIdle) && !ack_s);
  assign accept     = tx_valid_i && tx_ready_o;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_data_d = req_data_q;
    done_d     = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_d = 1'b0;
        // A stale ack left over from a reset blocks a new request.
        if (pend_vld_q && !ack_s) begin
          launch     = 1'b1;
          req_data_d = pend_q;
          req_d      = 1'b1;
          state_d    = StAssert;
        end
      end
      StAssert: begin
        req_d = 1'b1;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StDeassert;
        end
      end
      StDeassert: begin
        req_d = 1'b0;
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (launch) begin
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = tx_data_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      req_q      <= 1'b0;
      req_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      req_q      <= req_d;
      req_data_q <= req_data_d;
      done_q     <= done_d;
    end
  end

  assign req_o      = req_q;
  assign req_data_o = req_data_q;
  assign done_o     = done_q;
  assign idle_o     = (state_q == StIdle) && !pend_vld_q;

endmodule

// File: tb/tb_full_handshake_tx.sv
// Scoreboard bench for full_handshake_tx: a reactive RX model acks requests,
// and a monitor checks every presented word against the accepted-word queue.
module tb_full_handshake_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_ready;
  logic        ack = 1'b0;
  logic        req;
  logic [31:0] req_data;
  logic        idle;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  // RX model control: hold suppresses all ack activity; fixed delay < 0 means random.
  bit          rx_hold = 1'b0;
  int          rx_fixed = -1;

  // Reference view of the synchronized ack, used for the stale-ack rule.
  logic        m_ack_d = 1'b0;
  logic        m_ack_s = 1'b0;
  logic        last_ack_s = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] held = '0;

  full_handshake_tx #(
    .DW (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .ack_i      (ack),
    .req_o      (req),
    .req_data_o (req_data),
    .idle_o     (idle),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic flag(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: condition not met (t=%0t)", name, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ack_d <= 1'b0;
      m_ack_s <= 1'b0;
    end else begin
      m_ack_d <= ack;
      m_ack_s <= m_ack_d;
    end
  end

  // RX model: raise ack some cycles after req, drop it some cycles after req falls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rx_hold && req === 1'b1 && !ack) begin
        repeat ((rx_fixed >= 0) ? rx_fixed : $urandom_range(0, 20)) @(posedge clk);
        #($urandom_range(1, 8));
        ack = 1'b1;
      end else if (!rx_hold && req === 1'b0 && ack) begin
        repeat ((rx_fixed >= 0) ? rx_fixed : $urandom_range(0, 20)) @(posedge clk);
        #($urandom_range(1, 8));
        ack = 1'b0;
      end
    end
  end

  // Monitor: pops the expected word on each req rise and checks invariants.
  always @(negedge clk) begin
    if (req === 1'b1 && !prev_req) begin
      chk("req_rise_ack_s", {31'd0, last_ack_s}, 32'd0);
      if (exp_q.size() == 0) begin
        flag("unexpected_word", 1'b0);
      end else begin
        chk("word_order", req_data, exp_q.pop_front());
      end
      held = req_data;
    end else if (req === 1'b1 && prev_req) begin
      chk("req_data_stable", req_data, held);
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_single", {31'd0, prev_done}, 32'd0);
    end
    prev_req   = (req === 1'b1);
    prev_done  = (done === 1'b1);
    last_ack_s = m_ack_s;
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input int limit);
    bit ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (tx_ready) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    tx_valid = 1'b0;
    flag("send_accepted", ok);
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (idle && !ack) begin
        ok = 1'b1;
        break;
      end
    end
    flag("wait_idle", ok);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    do_reset(2);
    @(negedge clk);
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_req_data", req_data, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_idle", {31'd0, idle}, 32'd1);
    chk("reset_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: single word, fixed 3-cycle RX response.
    rx_fixed = 3;
    d0 = done_cnt;
    send(32'hDEADBEEF, 10);
    @(negedge clk);
    chk("t1_req_before", {31'd0, req}, 32'd0);
    @(negedge clk);
    chk("t1_req_after", {31'd0, req}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle(100);
    chk("t1_done_count", done_cnt - d0, 32'd1);
    chk("t1_idle", {31'd0, idle}, 32'd1);
    chk("t1_data_kept", req_data, 32'hDEADBEEF);

    // 2: two words back to back, third attempt must be refused.
    d0 = done_cnt;
    send(32'h1, 2);
    send(32'h2, 2);
    tx_valid = 1'b1;
    tx_data  = 32'h3;
    @(negedge clk);
    chk("t2_ready_full", {31'd0, tx_ready}, 32'd0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle(200);
    chk("t2_done_count", done_cnt - d0, 32'd2);
    chk("t2_queue_empty", exp_q.size(), 32'd0);

    // 3: ack held high across reset release blocks a new request.
    rx_hold = 1'b1;
    ack = 1'b1;
    do_reset(2);
    repeat (4) @(posedge clk);
    #1;
    d0 = done_cnt;
    send(32'hA5A5A5A5, 10);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t3_req_blocked", {31'd0, req}, 32'd0);
    @(posedge clk);
    #1;
    rx_hold = 1'b0;
    wait_idle(100);
    chk("t3_done_count", done_cnt - d0, 32'd1);
    chk("t3_data", req_data, 32'hA5A5A5A5);

    // 4: reset while in ASSERT with a word pending.
    rx_hold = 1'b1;
    send(32'h11, 10);
    @(posedge clk);
    #1;
    send(32'h22, 10);
    @(negedge clk);
    chk("t4_ready_full", {31'd0, tx_ready}, 32'd0);
    chk("t4_req_high", {31'd0, req}, 32'd1);
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    chk("t4_req_reset", {31'd0, req}, 32'd0);
    chk("t4_ready_reset", {31'd0, tx_ready}, 32'd1);
    chk("t4_idle_reset", {31'd0, idle}, 32'd1);
    @(posedge clk);
    #1;
    rx_hold = 1'b0;
    d0 = done_cnt;
    send(32'h33, 10);
    wait_idle(100);
    chk("t4_done_count", done_cnt - d0, 32'd1);

    // 5: random words, random gaps and ack delays.
    rx_fixed = -1;
    d0 = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send($urandom, 200);
    end
    wait_idle(200);
    chk("t5_done_count", done_cnt - d0, 32'd1000);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
